// File: rtl/uart_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_slot_pkg
// Description : Shared types and constants for the uart_core slot arbiter.
//               UART register map, arbiter FSM state encoding, CTRL register
//               field constants and an address-decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_slot_pkg;

  // uart_core register map
  typedef enum logic [4:0] {
    CTRL_REG  = 5'b00000,
    READ_REG  = 5'b00010,
    WRITE_REG = 5'b00011
  } uart_reg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REJECT = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  // CTRL_REG fields: dvsr [10:0], stop bits [14:13], 7-bit data select [15]
  localparam int         DATA_BITS_7   = 15;
  localparam int         STOP_BITS_LSB = 13;
  localparam logic [1:0] STOP_BITS_1_5 = 2'b01;
  localparam logic [1:0] STOP_BITS_2   = 2'b10;

  // True for any address that uart_core actually decodes
  function automatic logic is_mapped(input logic [4:0] addr);
    return (addr == CTRL_REG) || (addr == READ_REG) || (addr == WRITE_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first active requester at or
//               above the priority pointer (with wrap-around); the pointer
//               moves to winner+1 when the grant is consumed.
// Ports       : clk, reset (async, active high)
//               req[N]  - request levels
//               advance - grant is being taken this cycle, move the pointer
//               gnt[N]  - one-hot grant (combinational)
//               any     - at least one request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_rot;
  logic [PW-1:0] w_off;
  int            w_win;
  int            w_next;

  // Rotate requests so that the pointer position lands at bit 0; the lowest
  // set bit of the rotated vector is then the offset of the winner.
  always_comb begin
    w_rot = N'({req, req} >> r_ptr);
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = PW'(j);
    end
    w_win = int'(r_ptr) + int'(w_off);
    if (w_win >= N) w_win = w_win - N;
    w_next = (w_win + 1 == N) ? 0 : w_win + 1;
  end

  assign any = |req;
  assign gnt = any ? (N'(1) << w_win) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && any) begin
      r_ptr <= PW'(w_next);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_slot_arbiter
// Description : Shares one uart_core slot between NUM_REQ requesters. Each
//               grant produces exactly one slot access (or a rejection),
//               followed by a one-cycle ack. Only CFG_OWNER may write CTRL.
// Ports       : clk, reset (async, active high)
//               req/req_we/req_addr/req_wdata - packed requester side
//               ack/err (one-hot pulse), req_rdata (held read data)
//               cs/read/write/reg_addr/wr_data/rd_data - uart_core slot
// Revision    : 1.0 - initial release
// ============================================================================
module uart_slot_arbiter
  import uart_slot_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CFG_OWNER = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      err,
  output logic [31:0]             req_rdata,
  output logic                    cs,
  output logic                    read,
  output logic                    write,
  output logic [4:0]              reg_addr,
  output logic [31:0]             wr_data,
  input  logic [31:0]             rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any;
  logic                w_advance;

  logic [IDX_W-1:0]    w_win_idx;
  logic                w_win_we;
  logic [4:0]          w_win_addr;
  logic [31:0]         w_win_wdata;
  logic                w_reject;

  logic [IDX_W-1:0]    r_idx;
  logic                r_we;

  logic                w_cs_d;
  logic                w_read_d;
  logic                w_write_d;
  logic [NUM_REQ-1:0]  w_ack_d;
  logic [NUM_REQ-1:0]  w_err_d;

  assign w_advance = (r_state == IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (w_advance),
    .gnt     (w_gnt),
    .any     (w_any)
  );

  // Select the winning requester's fields from the packed buses
  always_comb begin
    w_win_idx   = '0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx   = IDX_W'(i);
        w_win_we    = req_we[i];
        w_win_addr  = req_addr[5*i +: 5];
        w_win_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // Reject decode is evaluated on the same fields that get latched at grant
  assign w_reject = !is_mapped(w_win_addr) ||
                    (w_win_we && (w_win_addr == CTRL_REG) &&
                     (int'(w_win_idx) != CFG_OWNER));

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = w_reject ? REJECT : ISSUE;
      ISSUE:   w_state_next = ACK;
      REJECT:  w_state_next = ACK;
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // Decoded from the next state and registered below, so every strobe and
  // ack comes straight from a flop and lasts exactly one cycle.
  always_comb begin
    w_cs_d    = (w_state_next == ISSUE);
    w_write_d = w_cs_d && w_win_we;
    w_read_d  = w_cs_d && !w_win_we;
    w_ack_d   = (w_state_next == ACK) ? (NUM_REQ'(1) << r_idx) : '0;
    w_err_d   = ((w_state_next == ACK) && (r_state == REJECT)) ?
                (NUM_REQ'(1) << r_idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs    <= 1'b0;
      read  <= 1'b0;
      write <= 1'b0;
      ack   <= '0;
      err   <= '0;
    end else begin
      cs    <= w_cs_d;
      read  <= w_read_d;
      write <= w_write_d;
      ack   <= w_ack_d;
      err   <= w_err_d;
    end
  end

  // Grant latch; slot address/data only move when an access is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_we     <= 1'b0;
      reg_addr <= '0;
      wr_data  <= '0;
    end else begin
      if ((r_state == IDLE) && w_any) begin
        r_idx <= w_win_idx;
        r_we  <= w_win_we;
      end
      if (w_cs_d) begin
        reg_addr <= w_win_addr;
        wr_data  <= w_win_wdata;
      end
    end
  end

  // Read data is taken while read is asserted (ISSUE -> ACK edge)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_rdata <= '0;
    end else if ((r_state == ISSUE) && !r_we) begin
      req_rdata <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_slot_arbiter
// Description : Directed self-checking bench for uart_slot_arbiter
//               (NUM_REQ=2, CFG_OWNER=0) with a small uart_core read model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] req_rdata;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  int tests  = 0;
  int failed = 0;

  // uart_core read model: first read returns 0x32, later reads 0x77
  logic popped = 1'b0;
  always @(posedge clk) if (read) popped <= 1'b1;
  assign rd_data = popped ? 32'h77 : 32'h32;

  always #5 clk = ~clk;

  uart_slot_arbiter #(.NUM_REQ(2), .CFG_OWNER(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .req_rdata (req_rdata),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic we, input logic [4:0] addr,
                         input logic [31:0] wd);
    req_we[idx]           = we;
    req_addr[5*idx +: 5]  = addr;
    req_wdata[32*idx +: 32] = wd;
  endtask

  // One full access from a single requester, starting from an IDLE cycle
  task automatic do_access(input int idx, input logic we, input logic [4:0] addr,
                           input logic [31:0] wd, input logic strobe, input logic e);
    logic [1:0] oh;
    oh = 2'(1) << idx;
    set_req(idx, we, addr, wd);
    req = oh;
    cyc();
    check("cs", 32'(cs), 32'(strobe));
    check("write", 32'(write), 32'(strobe & we));
    check("read", 32'(read), 32'(strobe & ~we));
    check("ack_early", 32'(ack), 32'h0);
    if (strobe) begin
      check("reg_addr", 32'(reg_addr), 32'(addr));
      if (we) check("wr_data", wr_data, wd);
    end
    cyc();
    check("ack", 32'(ack), 32'(oh));
    check("err", 32'(err), e ? 32'(oh) : 32'h0);
    check("cs_off", 32'(cs), 32'h0);
    req = 2'b00;
    cyc();
    check("ack_off", 32'(ack), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    cyc();
    cyc();
    // Reset state
    check("rst_cs", 32'({cs, read, write}), 32'h0);
    check("rst_ack", 32'({ack, err}), 32'h0);
    check("rst_addr", 32'(reg_addr), 32'h0);
    check("rst_wdata", wr_data, 32'h0);
    check("rst_rdata", req_rdata, 32'h0);
    reset = 1'b0;

    // Write WRITE_REG 0x33 from req0
    do_access(0, 1'b1, 5'b00011, 32'h33, 1'b1, 1'b0);
    // Read READ_REG from req1, captured 0x32
    do_access(1, 1'b0, 5'b00010, 32'h0, 1'b1, 1'b0);
    check("rdata_read", req_rdata, 32'h32);
    // Following write leaves the read data untouched
    do_access(0, 1'b1, 5'b00011, 32'h44, 1'b1, 1'b0);
    check("rdata_hold", req_rdata, 32'h32);
    check("addr_hold", 32'(reg_addr), 32'h3);

    // Contention from reset: grants 0,1,0,1 then only req1
    reset = 1'b1;
    set_req(0, 1'b1, 5'b00011, 32'hA0);
    set_req(1, 1'b1, 5'b00011, 32'hA1);
    req = 2'b11;
    cyc();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cyc();
      check("cont_cs", 32'(cs), 32'h1);
      check("cont_wd", wr_data, (r % 2 == 0) ? 32'hA0 : 32'hA1);
      cyc();
      check("cont_ack", 32'(ack), (r % 2 == 0) ? 32'h1 : 32'h2);
      if (r == 3) req = 2'b10;
      cyc();
      check("cont_idle", 32'({cs, ack}), 32'h0);
    end
    for (int r = 0; r < 2; r++) begin
      cyc();
      check("solo_wd", wr_data, 32'hA1);
      cyc();
      check("solo_ack", 32'(ack), 32'h2);
      cyc();
    end
    req = 2'b00;
    cyc();

    // Config lock: req1 write to CTRL rejected, req0 accepted
    do_access(1, 1'b1, 5'b00000, 32'h0000A28A, 1'b0, 1'b1);
    check("rej_addr_hold", 32'(reg_addr), 32'h3);
    do_access(0, 1'b1, 5'b00000, 32'h0000A28A, 1'b1, 1'b0);
    // CTRL read by a non-owner is forwarded
    do_access(1, 1'b0, 5'b00000, 32'h0, 1'b1, 1'b0);
    check("rdata_ctrl", req_rdata, 32'h77);
    // Unmapped address
    do_access(0, 1'b1, 5'b00101, 32'h5, 1'b0, 1'b1);
    do_access(0, 1'b0, 5'b00101, 32'h0, 1'b0, 1'b1);
    check("rdata_rej", req_rdata, 32'h77);

    // Reset during ISSUE: strobes drop at once, no ack, req1 served after
    set_req(0, 1'b1, 5'b00011, 32'h66);
    set_req(1, 1'b1, 5'b00011, 32'h55);
    req = 2'b01;
    cyc();
    check("pre_rst_cs", 32'({cs, write}), 32'h3);
    reset = 1'b1;
    req = 2'b10;
    #1;
    check("async_rst", 32'({cs, write, read}), 32'h0);
    cyc();
    check("rst_no_ack", 32'(ack), 32'h0);
    reset = 1'b0;
    cyc();
    check("post_rst_cs", 32'(cs), 32'h1);
    check("post_rst_wd", wr_data, 32'h55);
    cyc();
    check("post_rst_ack", 32'(ack), 32'h2);
    req = 2'b00;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
